// File: rtl/uart_packet_tx.sv
// uart_packet_tx: serialises up to NBYTES bytes from a captured buffer onto one UART line.
// Each byte is sent as a start bit (0), d0..d7 LSB first, and a stop bit (1).
// Byte order is chosen per packet, and an optional idle gap can be inserted between bytes.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit after d7.
// With parity enabled, each frame is 11 bit-times instead of 10.
// All outputs are registered one cycle behind the FSM state. The line therefore falls one
// cycle after the accept edge, and done rises one cycle after the last stop bit is counted.
module uart_packet_tx #(
   parameter int unsigned NBYTES       = 64,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned GAP_BITS     = 0,
   localparam int unsigned LW          = $clog2(NBYTES + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NBYTES*8-1:0] data_in,
   input  logic [LW-1:0]       len,
   input  logic                msb_first,
   output logic                uart_tx,
   output logic                busy,
   output logic                done,
   output logic [LW-1:0]       byte_cnt
);

   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam int unsigned GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

   localparam logic [LW-1:0] LenMax   = LW'(NBYTES);
   localparam logic [IW-1:0] IdxTop   = IW'(NBYTES - 1);
   localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GapLast  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StGap,
      StFin
`ifdef UART_TX_PARITY_EN
      , StParity
`endif
   } state_e;

   state_e              state_q;
   logic [NBYTES*8-1:0] buf_q;
   logic [LW-1:0]       len_q;
   logic [LW-1:0]       byte_cnt_q;
   logic                msb_q;
   logic [IW-1:0]       idx_q;
   logic [CW-1:0]       baud_q;
   logic [2:0]          bit_q;
   logic [GW-1:0]       gap_q;
   logic                tx_q;
   logic                busy_q;
   logic                done_q;

   logic [7:0]          cur_byte;
   logic [LW-1:0]       len_res;
   logic                bit_tick;
   logic                last_byte;
   logic                tx_d;

   // Byte under transmission, selected from the captured buffer by the running index
   always_comb begin
      cur_byte = buf_q[{idx_q, 3'b000} +: 8];
   end

   // Resolve length (0 or oversize means a full buffer) and decode bit/byte boundaries
   always_comb begin
      len_res   = ((len == '0) || (len > LenMax)) ? LenMax : len;
      bit_tick  = (baud_q == BaudLast);
      last_byte = ((byte_cnt_q + LW'(1)) == len_q);
   end

   // Line level implied by the current state; registered into tx_q below
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = cur_byte[bit_q];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = ^cur_byte;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // Packet FSM with baud, bit, gap and byte counters plus registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         buf_q      <= '0;
         len_q      <= '0;
         msb_q      <= 1'b0;
         idx_q      <= '0;
         baud_q     <= '0;
         bit_q      <= '0;
         gap_q      <= '0;
         byte_cnt_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= (state_q != StIdle) && (state_q != StFin);
         done_q <= (state_q == StFin);

         if ((state_q != StIdle) && (state_q != StFin)) begin
            baud_q <= bit_tick ? '0 : baud_q + 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (start) begin
                  buf_q      <= data_in;
                  len_q      <= len_res;
                  msb_q      <= msb_first;
                  idx_q      <= msb_first ? IdxTop : '0;
                  byte_cnt_q <= '0;
                  baud_q     <= '0;
                  state_q    <= StStart;
               end
            end
            StStart: begin
               if (bit_tick) begin
                  bit_q   <= '0;
                  state_q <= StData;
               end
            end
            StData: begin
               if (bit_tick) begin
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= StParity;
`else
                     state_q <= StStop;
`endif
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_tick) begin
                  state_q <= StStop;
               end
            end
`endif
            StStop: begin
               if (bit_tick) begin
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  if (last_byte) begin
                     state_q <= StFin;
                  end else begin
                     // Only stepped when another byte follows, so the index never wraps
                     idx_q <= msb_q ? idx_q - 1'b1 : idx_q + 1'b1;
                     if (GAP_BITS > 0) begin
                        gap_q   <= '0;
                        state_q <= StGap;
                     end else begin
                        state_q <= StStart;
                     end
                  end
               end
            end
            StGap: begin
               if (bit_tick) begin
                  if (gap_q == GapLast) begin
                     state_q <= StStart;
                  end else begin
                     gap_q <= gap_q + 1'b1;
                  end
               end
            end
            StFin: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign uart_tx  = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: scoreboard bench for uart_packet_tx (NBYTES=4, CLKS_PER_BIT=4).
// Two instances are used: dut_a runs with GAP_BITS=0, and dut_g runs with GAP_BITS=2.
// A line monitor per instance decodes the frames and pops the expected bytes from a queue.
module tb_uart_packet_tx;

   localparam int CPB = 4;
   localparam int NB  = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB  = 11;
`else
   localparam int FB  = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, start_g = 1'b0;
   logic [31:0] data_in = '0, data_g = '0;
   logic [2:0]  len = '0, len_g = '0;
   logic        msb = 1'b0, msb_g = 1'b0;
   logic        tx, tx_g, busy, busy_g, done, done_g;
   logic [2:0]  bcnt, bcnt_g;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          rst_events = 0;
   int          done_a_cnt = 0;
   int          done_g_cnt = 0;
   logic [7:0]  exp_a[$];
   logic [7:0]  exp_g[$];
   int          starts_a[$];
   int          starts_g[$];

   uart_packet_tx #(.NBYTES(NB), .CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .len(len), .msb_first(msb),
      .uart_tx(tx), .busy(busy), .done(done), .byte_cnt(bcnt)
   );

   uart_packet_tx #(.NBYTES(NB), .CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut_g (
      .clk(clk), .rst(rst), .start(start_g), .data_in(data_g), .len(len_g), .msb_first(msb_g),
      .uart_tx(tx_g), .busy(busy_g), .done(done_g), .byte_cnt(bcnt_g)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge rst) rst_events <= rst_events + 1;
   always @(negedge clk) begin
      if (done === 1'b1) done_a_cnt <= done_a_cnt + 1;
      if (done_g === 1'b1) done_g_cnt <= done_g_cnt + 1;
   end

   // Expected done edge, counted from the accept edge
   function automatic int done_at(input int n, input int gap);
      return 1 + n * FB * CPB + (n - 1) * gap * CPB;
   endfunction

   // Reference model: clamp the length and push the bytes in line order
   function automatic void push_exp(input bit g, input logic [31:0] d, input int l, input bit m);
      int n;
      logic [7:0] b;
      n = (l == 0 || l > NB) ? NB : l;
      for (int i = 0; i < n; i++) begin
         b = m ? d[8*(NB-1-i) +: 8] : d[8*i +: 8];
         if (g) exp_g.push_back(b);
         else   exp_a.push_back(b);
      end
   endfunction

   // Decode one frame. Detection happens at the first low sample, and each bit is then
   // sampled in its middle.
   task automatic mon_frame(input bit g);
      logic [FB-1:0] bits;
      logic [7:0]    e;
      int            rs;
      bits = '0;
      rs   = rst_events;
      if (g) starts_g.push_back(cyc);
      else   starts_a.push_back(cyc);
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < FB; k++) begin
         bits[k] = g ? tx_g : tx;
         if (k < FB - 1) repeat (CPB) @(negedge clk);
      end
      if (rs != rst_events || rst === 1'b1) return;
      n_cmp++;
      if ((g && exp_g.size() == 0) || (!g && exp_a.size() == 0)) begin
         n_bad++;
         $display("FAIL unexpected_frame dut%0d: got 0x%02h, required no frame", g, bits[8:1]);
         return;
      end
      if (g) e = exp_g.pop_front();
      else   e = exp_a.pop_front();
      if (bits[8:1] !== e) begin
         n_bad++;
         $display("FAIL frame_data dut%0d: got 0x%02h, required 0x%02h", g, bits[8:1], e);
      end
      n_cmp++;
      if ({bits[FB-1], bits[0]} !== 2'b10) begin
         n_bad++;
         $display("FAIL frame_bounds dut%0d: stop/start %b, required 10", g,
                  {bits[FB-1], bits[0]});
      end
`ifdef UART_TX_PARITY_EN
      n_cmp++;
      if (bits[9] !== ^e) begin
         n_bad++;
         $display("FAIL parity dut%0d: got %b, required %b", g, bits[9], ^e);
      end
`endif
   endtask

   initial begin : mon_a
      forever begin
         @(negedge clk);
         if (tx === 1'b0) mon_frame(1'b0);
      end
   end

   initial begin : mon_g
      forever begin
         @(negedge clk);
         if (tx_g === 1'b0) mon_frame(1'b1);
      end
   end

   task automatic send(input bit g, input logic [31:0] d, input logic [2:0] l, input bit m,
                       input bit push, output int acc);
      @(negedge clk);
      if (g) begin
         data_g = d; len_g = l; msb_g = m; start_g = 1'b1;
      end else begin
         data_in = d; len = l; msb = m; start = 1'b1;
      end
      if (push) push_exp(g, d, int'(l), m);
      @(posedge clk);
      #1;
      acc = cyc;
      start = 1'b0;
      start_g = 1'b0;
   endtask

   task automatic wait_done(input bit g, input int budget, output int when, output bit ok);
      ok = 1'b0;
      when = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if ((g ? done_g : done) === 1'b1) begin
            ok = 1'b1;
            when = cyc;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || tx_g !== 1'b1) begin
         n_bad++; $display("FAIL reset_tx: got %b/%b, required 1/1", tx, tx_g);
      end
      n_cmp++;
      if (busy !== 1'b0 || busy_g !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy: got %b/%b, required 0/0", busy, busy_g);
      end
      n_cmp++;
      if (done !== 1'b0 || done_g !== 1'b0) begin
         n_bad++; $display("FAIL reset_done: got %b/%b, required 0/0", done, done_g);
      end
      n_cmp++;
      if (bcnt !== 3'd0 || bcnt_g !== 3'd0) begin
         n_bad++; $display("FAIL reset_byte_cnt: got %0d/%0d, required 0/0", bcnt, bcnt_g);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_basic();
      int acc, d;
      bit ok;
      send(1'b0, 32'h44332211, 3'd4, 1'b0, 1'b1, acc);
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL basic_cycle0: tx/busy %b%b, required 10", tx, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         n_bad++; $display("FAIL basic_cycle1: tx/busy %b%b, required 01", tx, busy);
      end
      wait_done(1'b0, 400, d, ok);
      n_cmp++;
      if (!ok || d - acc != done_at(4, 0)) begin
         n_bad++; $display("FAIL basic_done_time: got %0d, required %0d", d - acc, done_at(4, 0));
      end
      n_cmp++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_bad++; $display("FAIL basic_done_state: busy/tx %b%b, required 01", busy, tx);
      end
      n_cmp++;
      if (bcnt !== 3'd4) begin
         n_bad++; $display("FAIL basic_byte_cnt: got %0d, required 4", bcnt);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL basic_done_width: got %b one cycle later, required 0", done);
      end
      n_cmp++;
      if (exp_a.size() != 0) begin
         n_bad++; $display("FAIL basic_pending: %0d bytes not seen, required 0", exp_a.size());
      end
   endtask

   task automatic test_msb_partial();
      int acc, d;
      bit ok;
      send(1'b0, 32'h44332211, 3'd2, 1'b1, 1'b1, acc);
      wait_done(1'b0, 400, d, ok);
      n_cmp++;
      if (!ok || d - acc != done_at(2, 0)) begin
         n_bad++; $display("FAIL msb_done_time: got %0d, required %0d", d - acc, done_at(2, 0));
      end
      n_cmp++;
      if (bcnt !== 3'd2) begin
         n_bad++; $display("FAIL msb_byte_cnt: got %0d, required 2", bcnt);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_a.size() != 0) begin
         n_bad++; $display("FAIL msb_pending: %0d bytes not seen, required 0", exp_a.size());
      end
   endtask

   task automatic test_gap_clamp();
      int acc, d;
      bit ok;
      starts_g.delete();
      send(1'b1, 32'h44332211, 3'd0, 1'b0, 1'b1, acc);
      wait_done(1'b1, 500, d, ok);
      n_cmp++;
      if (!ok || d - acc != done_at(4, 2)) begin
         n_bad++; $display("FAIL gap_done_time: got %0d, required %0d", d - acc, done_at(4, 2));
      end
      n_cmp++;
      if (bcnt_g !== 3'd4) begin
         n_bad++; $display("FAIL gap_byte_cnt: got %0d, required 4", bcnt_g);
      end
      n_cmp++;
      if (starts_g.size() != 4) begin
         n_bad++; $display("FAIL gap_frames: got %0d, required 4", starts_g.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (starts_g[i] - starts_g[i-1] != FB * CPB + 2 * CPB) begin
               n_bad++;
               $display("FAIL gap_spacing: got %0d, required %0d",
                        starts_g[i] - starts_g[i-1], FB * CPB + 2 * CPB);
            end
         end
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_g.size() != 0) begin
         n_bad++; $display("FAIL gap_pending: %0d bytes not seen, required 0", exp_g.size());
      end
   endtask

   task automatic test_ignored();
      int acc, d, dc0;
      bit ok;
      dc0 = done_a_cnt;
      send(1'b0, 32'h44332211, 3'd4, 1'b0, 1'b1, acc);
      for (int i = 0; i < 200 && cyc < acc + 50; i++) @(negedge clk);
      data_in = 32'hAABBCCDD; len = 3'd1; msb = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(1'b0, 400, d, ok);
      n_cmp++;
      if (!ok || d - acc != done_at(4, 0)) begin
         n_bad++; $display("FAIL ign_done_time: got %0d, required %0d", d - acc, done_at(4, 0));
      end
      repeat (20) @(negedge clk);
      n_cmp++;
      if (done_a_cnt - dc0 != 1) begin
         n_bad++; $display("FAIL ign_done_count: got %0d, required 1", done_a_cnt - dc0);
      end
      n_cmp++;
      if (exp_a.size() != 0) begin
         n_bad++; $display("FAIL ign_pending: %0d bytes not seen, required 0", exp_a.size());
      end
   endtask

   task automatic test_back_to_back();
      int d1, d2;
      bit ok;
      starts_a.delete();
      @(negedge clk);
      data_in = 32'h000000A5; len = 3'd1; msb = 1'b0; start = 1'b1;
      push_exp(1'b0, 32'h000000A5, 1, 1'b0);
      wait_done(1'b0, 200, d1, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL b2b_first_done: got timeout, required a pulse");
      end
      // Start stays high through the done cycle and is accepted at its closing edge
      data_in = 32'h0000005C;
      push_exp(1'b0, 32'h0000005C, 1, 1'b0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(1'b0, 200, d2, ok);
      n_cmp++;
      if (!ok || d2 - d1 != 1 + done_at(1, 0)) begin
         n_bad++; $display("FAIL b2b_second_done: got %0d, required %0d", d2 - d1, 1 + done_at(1, 0));
      end
      n_cmp++;
      if (starts_a.size() != 2) begin
         n_bad++; $display("FAIL b2b_frames: got %0d, required 2", starts_a.size());
      end else begin
         n_cmp++;
         if (starts_a[1] - d1 != 2) begin
            n_bad++; $display("FAIL b2b_start_latency: got %0d, required 2", starts_a[1] - d1);
         end
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_a.size() != 0) begin
         n_bad++; $display("FAIL b2b_pending: %0d bytes not seen, required 0", exp_a.size());
      end
   endtask

   task automatic test_parity_frame();
      int acc, d;
      bit ok;
      send(1'b0, 32'h00000007, 3'd1, 1'b0, 1'b1, acc);
      wait_done(1'b0, 200, d, ok);
      n_cmp++;
      if (!ok || d - acc != done_at(1, 0)) begin
         n_bad++; $display("FAIL frame_len_done: got %0d, required %0d", d - acc, done_at(1, 0));
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_a.size() != 0) begin
         n_bad++; $display("FAIL frame_len_pending: %0d not seen, required 0", exp_a.size());
      end
   endtask

   task automatic test_abort();
      int acc, dc0;
      dc0 = done_a_cnt;
      send(1'b0, 32'h44332211, 3'd4, 1'b0, 1'b0, acc);
      for (int i = 0; i < 100 && cyc < acc + 10; i++) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL abort_async: tx/busy/done %b%b%b, required 100", tx, busy, done);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      n_cmp++;
      if (done_a_cnt != dc0) begin
         n_bad++; $display("FAIL abort_done: got %0d pulses, required 0", done_a_cnt - dc0);
      end
      n_cmp++;
      if (tx !== 1'b1 || busy !== 1'b0 || bcnt !== 3'd0) begin
         n_bad++; $display("FAIL abort_idle: tx/busy/cnt %b%b%0d, required 1 0 0", tx, busy, bcnt);
      end
   endtask

   initial begin : main
      test_reset();
      test_basic();
      test_msb_partial();
      test_gap_clamp();
      test_ignored();
      test_back_to_back();
      test_parity_frame();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
